// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detection, tenth-second prescaler,
// lap freeze and blanking of the display when the limit is reached.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 10,
    parameter int FLASH_DIV = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       mode_down,
    input  logic       at_limit,
    output logic       tick_en,
    output logic       count_down,
    output logic       load_preset,
    output logic       clear_cnt,
    output logic       lap_hold,
    output logic       blank,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    hist_q, hist_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          tick_q, tick_d;
    logic          dir_q, dir_d;
    logic          load_q, load_d;
    logic          clr_q, clr_d;
    logic          lap_q, lap_d;
    logic          blank_q, blank_d;

    logic          ev_clear_s, ev_stop_s, ev_start_s, ev_lap_s;

    // Rising-edge events, masked so only the highest-priority one survives
    always_comb begin
        ev_clear_s = btn_clear & ~hist_q[3];
        ev_stop_s  = btn_stop  & ~hist_q[2] & ~ev_clear_s;
        ev_start_s = btn_start & ~hist_q[1] & ~ev_clear_s & ~ev_stop_s;
        ev_lap_s   = btn_lap   & ~hist_q[0] & ~ev_clear_s & ~ev_stop_s & ~ev_start_s;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        hist_d  = {btn_clear, btn_stop, btn_start, btn_lap};
        presc_d = presc_q;
        flash_d = flash_q;
        tick_d  = 1'b0;
        load_d  = 1'b0;
        clr_d   = 1'b0;
        dir_d   = dir_q;
        lap_d   = lap_q;
        blank_d = blank_q;
        if (ev_clear_s) begin
            state_d = S_IDLE;
            clr_d   = 1'b1;
            lap_d   = 1'b0;
            blank_d = 1'b0;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_start_s) begin
                        state_d = S_RUN;
                        dir_d   = mode_down;
                        load_d  = mode_down;
                        presc_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (ev_stop_s) begin
                        state_d = S_PAUSE;
                    end else if (at_limit) begin
                        // Terminal value reached: suppress the pending tick
                        state_d = S_DONE;
                        lap_d   = 1'b0;
                        flash_d = '0;
                        blank_d = 1'b1;
                    end else begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                        if (ev_lap_s) begin
                            lap_d = ~lap_q;
                        end else begin
                            lap_d = lap_q;
                        end
                    end
                end
                S_PAUSE: begin
                    if (ev_start_s) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if (ev_stop_s) begin
                        state_d = S_IDLE;
                        blank_d = 1'b0;
                    end else if (flash_q == FLASH_MAX) begin
                        flash_d = '0;
                        blank_d = ~blank_q;
                    end else begin
                        flash_d = flash_q + FW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; history set to 1 so held buttons stay silent
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hist_q  <= 4'b1111;
            presc_q <= '0;
            flash_q <= '0;
            tick_q  <= 1'b0;
            dir_q   <= 1'b0;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            lap_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            presc_q <= presc_d;
            flash_q <= flash_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            clr_q   <= clr_d;
            lap_q   <= lap_d;
            blank_q <= blank_d;
        end
    end

    assign tick_en     = tick_q;
    assign count_down  = dir_q;
    assign load_preset = load_q;
    assign clear_cnt   = clr_q;
    assign lap_hold    = lap_q;
    assign blank       = blank_q;
    assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, FLASH_DIV=3.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic       mode_down = 1'b0, at_limit = 1'b0;
    logic       tick_en, count_down, load_preset, clear_cnt, lap_hold, blank;
    logic [1:0] state;
    logic [7:0] obs;
    logic [7:0] exp_v;
    int         n_vec = 0;
    int         n_err = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .FLASH_DIV(3)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .mode_down(mode_down), .at_limit(at_limit),
        .tick_en(tick_en), .count_down(count_down), .load_preset(load_preset),
        .clear_cnt(clear_cnt), .lap_hold(lap_hold), .blank(blank), .state(state)
    );

    always #5 clk = ~clk;

    // {state[1:0], tick_en, count_down, load_preset, clear_cnt, lap_hold, blank}
    assign obs = {state, tick_en, count_down, load_preset, clear_cnt, lap_hold, blank};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL reset got=%b exp=%b", obs, 8'b00_000000); end
        reset = 1'b0;
        step();
        n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", obs, 8'b00_000000); end
    endtask

    task automatic test_count_up();
        mode_down = 1'b0;
        btn_start = 1'b1;
        step();
        n_vec++; if (obs !== 8'b01_000000) begin n_err++; $display("FAIL up_start got=%b exp=%b", obs, 8'b01_000000); end
        btn_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_v = (i % 4 == 0) ? 8'b01_100000 : 8'b01_000000;
            n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL up_tick[%0d] got=%b exp=%b", i, obs, exp_v); end
        end
        btn_clear = 1'b1;
        step();
        n_vec++; if (obs !== 8'b00_000100) begin n_err++; $display("FAIL up_clear got=%b exp=%b", obs, 8'b00_000100); end
        btn_clear = 1'b0;
        step();
        n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL up_clear_end got=%b exp=%b", obs, 8'b00_000000); end
    endtask

    task automatic test_pause_resume();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        step();
        n_vec++; if (obs !== 8'b01_000000) begin n_err++; $display("FAIL pr_run got=%b exp=%b", obs, 8'b01_000000); end
        btn_stop = 1'b1;
        step();
        n_vec++; if (obs !== 8'b10_000000) begin n_err++; $display("FAIL pr_pause got=%b exp=%b", obs, 8'b10_000000); end
        btn_stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) btn_stop = 1'b1;
            step();
            btn_stop = 1'b0;
            n_vec++; if (obs !== 8'b10_000000) begin n_err++; $display("FAIL pr_hold[%0d] got=%b exp=%b", i, obs, 8'b10_000000); end
        end
        btn_start = 1'b1;
        step();
        n_vec++; if (obs !== 8'b01_000000) begin n_err++; $display("FAIL pr_resume got=%b exp=%b", obs, 8'b01_000000); end
        btn_start = 1'b0;
        step();
        n_vec++; if (obs !== 8'b01_000000) begin n_err++; $display("FAIL pr_r1 got=%b exp=%b", obs, 8'b01_000000); end
        step();
        n_vec++; if (obs !== 8'b01_100000) begin n_err++; $display("FAIL pr_tick got=%b exp=%b", obs, 8'b01_100000); end
        step();
        n_vec++; if (obs !== 8'b01_000000) begin n_err++; $display("FAIL pr_after got=%b exp=%b", obs, 8'b01_000000); end
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        n_vec++; if (obs !== 8'b00_000100) begin n_err++; $display("FAIL pr_clear got=%b exp=%b", obs, 8'b00_000100); end
    endtask

    task automatic test_lap();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        btn_lap = 1'b1;
        step();
        n_vec++; if ({state, lap_hold} !== 3'b01_1) begin n_err++; $display("FAIL lap_on got=%b exp=%b", {state, lap_hold}, 3'b01_1); end
        btn_lap = 1'b0;
        step();
        btn_lap = 1'b1;
        step();
        n_vec++; if ({state, lap_hold} !== 3'b01_0) begin n_err++; $display("FAIL lap_off got=%b exp=%b", {state, lap_hold}, 3'b01_0); end
        btn_lap = 1'b0;
        step();
        btn_lap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++; if ({state, lap_hold} !== 3'b01_1) begin n_err++; $display("FAIL lap_held[%0d] got=%b exp=%b", i, {state, lap_hold}, 3'b01_1); end
        end
        btn_lap = 1'b0;
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;
        btn_lap = 1'b1;
        step();
        n_vec++; if ({state, lap_hold} !== 3'b10_1) begin n_err++; $display("FAIL lap_pause got=%b exp=%b", {state, lap_hold}, 3'b10_1); end
        btn_lap = 1'b0;
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        n_vec++; if (obs !== 8'b00_000100) begin n_err++; $display("FAIL lap_clear got=%b exp=%b", obs, 8'b00_000100); end
    endtask

    task automatic test_back_to_back();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        step();
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        btn_clear = 1'b1;
        step();
        n_vec++; if (obs !== 8'b00_000100) begin n_err++; $display("FAIL b2b_clear got=%b exp=%b", obs, 8'b00_000100); end
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        step();
        n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL b2b_idle got=%b exp=%b", obs, 8'b00_000000); end
    endtask

    task automatic test_countdown_done();
        mode_down = 1'b1;
        btn_start = 1'b1;
        step();
        n_vec++; if (obs !== 8'b01_011000) begin n_err++; $display("FAIL dn_preset got=%b exp=%b", obs, 8'b01_011000); end
        btn_start = 1'b0;
        mode_down = 1'b0;
        step();
        n_vec++; if (obs !== 8'b01_010000) begin n_err++; $display("FAIL dn_run got=%b exp=%b", obs, 8'b01_010000); end
        at_limit = 1'b1;
        step();
        n_vec++; if (obs !== 8'b11_010001) begin n_err++; $display("FAIL dn_done got=%b exp=%b", obs, 8'b11_010001); end
        for (int i = 1; i <= 7; i++) begin
            if (i == 4) begin btn_start = 1'b1; btn_lap = 1'b1; end
            step();
            btn_start = 1'b0;
            btn_lap = 1'b0;
            exp_v = ((i / 3) % 2 == 0) ? 8'b11_010001 : 8'b11_010000;
            n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL dn_flash[%0d] got=%b exp=%b", i, obs, exp_v); end
        end
        at_limit = 1'b0;
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;
        n_vec++; if (obs !== 8'b00_010000) begin n_err++; $display("FAIL dn_stop got=%b exp=%b", obs, 8'b00_010000); end
    endtask

    task automatic test_reset_mid_done();
        mode_down = 1'b0;
        at_limit = 1'b1;
        btn_start = 1'b1;
        step();
        step();
        n_vec++; if (obs !== 8'b11_000001) begin n_err++; $display("FAIL rd_done got=%b exp=%b", obs, 8'b11_000001); end
        reset = 1'b1;
        step();
        n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL rd_reset got=%b exp=%b", obs, 8'b00_000000); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (obs !== 8'b00_000000) begin n_err++; $display("FAIL rd_held[%0d] got=%b exp=%b", i, obs, 8'b00_000000); end
        end
        btn_start = 1'b0;
        at_limit = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_pause_resume();
        test_lap();
        test_back_to_back();
        test_countdown_done();
        test_reset_mid_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
